// File: rtl/branch_target_predictor.sv
// branch_target_predictor: BTB with static/bimodal/gshare direction prediction,
// misprediction flush/redirect and saturating prediction statistics.
module branch_target_predictor #(
    parameter int WORD_SIZE  = 16,
    parameter int INDEX_BITS = 4,
    parameter int CTR_BITS   = 2,
    parameter int MODE       = 1
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic [WORD_SIZE-1:0] pc,
    output logic [WORD_SIZE-1:0] next_pc,
    output logic                 pred_taken,
    output logic                 pred_hit,
    input  logic                 upd_valid,
    input  logic [WORD_SIZE-1:0] upd_pc,
    input  logic                 upd_is_branch,
    input  logic                 upd_taken,
    input  logic [WORD_SIZE-1:0] upd_target,
    input  logic [WORD_SIZE-1:0] upd_pred_pc,
    output logic                 flush,
    output logic [WORD_SIZE-1:0] redirect_pc,
    output logic [WORD_SIZE-1:0] pred_count,
    output logic [WORD_SIZE-1:0] mispred_count
);
    localparam int ENTRIES = 1 << INDEX_BITS;
    localparam int TAG_BITS = WORD_SIZE - INDEX_BITS;
    localparam logic [CTR_BITS-1:0] CTR_MAX = '1;
    localparam logic [CTR_BITS-1:0] CTR_WT = CTR_BITS'(1 << (CTR_BITS - 1));
    localparam logic [CTR_BITS-1:0] CTR_WNT = CTR_BITS'((1 << (CTR_BITS - 1)) - 1);

    logic [ENTRIES-1:0]    valid;
    logic [ENTRIES-1:0]    jump;
    logic [TAG_BITS-1:0]   tag [ENTRIES];
    logic [WORD_SIZE-1:0]  target [ENTRIES];
    logic [CTR_BITS-1:0]   pht [ENTRIES];
    logic [INDEX_BITS-1:0] ghr, l_idx, l_pidx, u_idx, u_pidx;
    logic                  u_hit;
    logic [WORD_SIZE-1:0]  actual;

    always_comb begin
        l_idx       = pc[INDEX_BITS-1:0];
        u_idx       = upd_pc[INDEX_BITS-1:0];
        l_pidx      = MODE == 2 ? l_idx ^ ghr : l_idx;
        u_pidx      = MODE == 2 ? u_idx ^ ghr : u_idx;
        pred_hit    = valid[l_idx] && tag[l_idx] == pc[WORD_SIZE-1:INDEX_BITS];
        u_hit       = valid[u_idx] && tag[u_idx] == upd_pc[WORD_SIZE-1:INDEX_BITS];
        pred_taken  = MODE != 0 && pred_hit && (jump[l_idx] || pht[l_pidx][CTR_BITS-1]);
        next_pc     = pred_taken ? target[l_idx] : pc + WORD_SIZE'(1);
        actual      = upd_taken ? upd_target : upd_pc + WORD_SIZE'(1);
        flush       = upd_valid && actual != upd_pred_pc;
        redirect_pc = actual;
    end

    // Entry payload needs no reset: it is only observed through a set valid bit.
    always_ff @(posedge clk) begin
        if (!reset_n && upd_valid && upd_taken) begin
            tag[u_idx]    <= upd_pc[WORD_SIZE-1:INDEX_BITS];
            target[u_idx] <= upd_target;
            jump[u_idx]   <= !upd_is_branch;
        end
    end

    always_ff @(posedge clk or posedge reset_n) begin
        if (reset_n) begin
            valid         <= '0;
            ghr           <= '0;
            pred_count    <= '0;
            mispred_count <= '0;
            for (int i = 0; i < ENTRIES; i++) pht[i] <= CTR_WNT;
        end else if (upd_valid) begin
            if (upd_taken) begin
                valid[u_idx] <= 1'b1;
                pht[u_pidx]  <= !upd_is_branch ? CTR_MAX :
                                !u_hit ? CTR_WT :
                                pht[u_pidx] == CTR_MAX ? CTR_MAX : pht[u_pidx] + CTR_BITS'(1);
            end else if (u_hit && pht[u_pidx] != '0) begin
                pht[u_pidx] <= pht[u_pidx] - CTR_BITS'(1);
            end
            if (upd_is_branch) ghr <= INDEX_BITS'({ghr, upd_taken});
            pred_count    <= pred_count + WORD_SIZE'(~&pred_count);
            mispred_count <= mispred_count + WORD_SIZE'(flush && ~&mispred_count);
        end
    end
endmodule

// File: tb/tb_branch_target_predictor.sv
// tb_branch_target_predictor: directed and model-driven scoreboard bench for a
// bimodal (dut) and a gshare (dut2) instance sharing lookup/update inputs.
module tb_branch_target_predictor;
    typedef struct packed {
        logic        rst;
        logic [15:0] pc;
        logic        uv;
        logic [15:0] upc;
        logic        br;
        logic        tk;
        logic [15:0] tgt;
        logic [15:0] ppc;
    } vec_t;

    typedef struct packed {
        logic [15:0] nx;
        logic        hit;
        logic        tk;
        logic        fl;
        logic [15:0] rd;
        logic [15:0] pcn;
        logic [15:0] mpn;
    } exp_t;

    logic        clk = 1'b0, reset_n = 1'b1, use2 = 1'b0, uv = 1'b0;
    logic [15:0] pc = '0, upd_pc = '0, upd_target = '0, upd_pred_pc = '0;
    logic        upd_is_branch = 1'b0, upd_taken = 1'b0;
    logic [15:0] next_pc, redirect_pc, pred_count, mispred_count;
    logic        pred_taken, pred_hit, flush;
    logic [15:0] next_pc2, redirect_pc2, pred_count2, mispred_count2;
    logic        pred_taken2, pred_hit2, flush2;
    exp_t        obs1, obs2;
    exp_t        q[$];
    int          n_vec = 0, n_err = 0;

    logic        mv[16], mj[16];
    logic [11:0] mt[16];
    logic [15:0] mtg[16];
    logic [1:0]  mc[16];
    logic [3:0]  mg;
    logic [15:0] mpc, mmp;

    branch_target_predictor #(.WORD_SIZE(16), .INDEX_BITS(4), .CTR_BITS(2), .MODE(1)) dut (
        .clk(clk), .reset_n(reset_n), .pc(pc), .next_pc(next_pc), .pred_taken(pred_taken),
        .pred_hit(pred_hit), .upd_valid(uv && !use2), .upd_pc(upd_pc), .upd_is_branch(upd_is_branch),
        .upd_taken(upd_taken), .upd_target(upd_target), .upd_pred_pc(upd_pred_pc), .flush(flush),
        .redirect_pc(redirect_pc), .pred_count(pred_count), .mispred_count(mispred_count)
    );

    branch_target_predictor #(.WORD_SIZE(16), .INDEX_BITS(4), .CTR_BITS(2), .MODE(2)) dut2 (
        .clk(clk), .reset_n(reset_n), .pc(pc), .next_pc(next_pc2), .pred_taken(pred_taken2),
        .pred_hit(pred_hit2), .upd_valid(uv && use2), .upd_pc(upd_pc), .upd_is_branch(upd_is_branch),
        .upd_taken(upd_taken), .upd_target(upd_target), .upd_pred_pc(upd_pred_pc), .flush(flush2),
        .redirect_pc(redirect_pc2), .pred_count(pred_count2), .mispred_count(mispred_count2)
    );

    assign obs1 = {next_pc, pred_hit, pred_taken, flush, redirect_pc, pred_count, mispred_count};
    assign obs2 = {next_pc2, pred_hit2, pred_taken2, flush2, redirect_pc2, pred_count2, mispred_count2};

    always #5 clk = ~clk;

    task automatic drive(input vec_t v);
        reset_n       = v.rst;
        pc            = v.pc;
        uv            = v.uv;
        upd_pc        = v.upc;
        upd_is_branch = v.br;
        upd_taken     = v.tk;
        upd_target    = v.tgt;
        upd_pred_pc   = v.ppc;
    endtask

    task automatic test_reset;
        vec_t v[2];
        exp_t x[2];
        exp_t e;
        v[0] = '{1, 16'h0010, 0, 16'h0000, 0, 0, 16'h0000, 16'h0000};
        x[0] = '{16'h0011, 0, 0, 0, 16'h0001, 0, 0};
        v[1] = '{1, 16'h0010, 1, 16'h0040, 1, 0, 16'h0000, 16'h0000};
        x[1] = '{16'h0011, 0, 0, 1, 16'h0041, 0, 0};
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            drive(v[i]);
            q.push_back(x[i]);
            #1;
            e = q.pop_front();
            n_vec++;
            if (obs1 !== e) begin
                n_err++;
                $display("FAIL reset[%0d]: got %p, expected %p", i, obs1, e);
            end
        end
    endtask

    task automatic test_cold_lookup;
        exp_t e;
        @(negedge clk);
        drive('{0, 16'h0010, 0, 16'h0000, 0, 0, 16'h0000, 16'h0000});
        q.push_back('{16'h0011, 0, 0, 0, 16'h0001, 0, 0});
        #1;
        e = q.pop_front();
        n_vec++;
        if (obs1 !== e) begin
            n_err++;
            $display("FAIL cold_lookup: got %p, expected %p", obs1, e);
        end
    endtask

    task automatic test_alloc;
        vec_t v[2];
        exp_t x[2];
        exp_t e;
        v[0] = '{0, 16'h0012, 1, 16'h0012, 1, 1, 16'h0005, 16'h0013};
        x[0] = '{16'h0013, 0, 0, 1, 16'h0005, 0, 0};
        v[1] = '{0, 16'h0012, 0, 16'h0000, 0, 0, 16'h0000, 16'h0000};
        x[1] = '{16'h0005, 1, 1, 0, 16'h0001, 1, 1};
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            drive(v[i]);
            q.push_back(x[i]);
            #1;
            e = q.pop_front();
            n_vec++;
            if (obs1 !== e) begin
                n_err++;
                $display("FAIL alloc[%0d]: got %p, expected %p", i, obs1, e);
            end
        end
    endtask

    task automatic test_saturation;
        vec_t v[6];
        exp_t x[6];
        exp_t e;
        for (int i = 0; i < 3; i++) begin
            v[i] = '{0, 16'h0012, 1, 16'h0012, 1, 1, 16'h0005, 16'h0005};
            x[i] = '{16'h0005, 1, 1, 0, 16'h0005, 16'(1 + i), 1};
        end
        v[3] = '{0, 16'h0012, 1, 16'h0012, 1, 0, 16'h0005, 16'h0013};
        x[3] = '{16'h0005, 1, 1, 0, 16'h0013, 4, 1};
        v[4] = '{0, 16'h0012, 1, 16'h0012, 1, 0, 16'h0005, 16'h0005};
        x[4] = '{16'h0005, 1, 1, 1, 16'h0013, 5, 1};
        v[5] = '{0, 16'h0012, 0, 16'h0000, 0, 0, 16'h0000, 16'h0000};
        x[5] = '{16'h0013, 1, 0, 0, 16'h0001, 6, 2};
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            drive(v[i]);
            q.push_back(x[i]);
            #1;
            e = q.pop_front();
            n_vec++;
            if (obs1 !== e) begin
                n_err++;
                $display("FAIL saturation[%0d]: got %p, expected %p", i, obs1, e);
            end
        end
    endtask

    task automatic test_alias_wrap;
        vec_t v[3];
        exp_t x[3];
        exp_t e;
        v[0] = '{0, 16'h0022, 0, 16'h0000, 0, 0, 16'h0000, 16'h0000};
        x[0] = '{16'h0023, 0, 0, 0, 16'h0001, 6, 2};
        v[1] = '{0, 16'hFFFF, 1, 16'hFFFF, 1, 0, 16'h0000, 16'h0000};
        x[1] = '{16'h0000, 0, 0, 0, 16'h0000, 6, 2};
        v[2] = '{0, 16'hFFFF, 0, 16'h0000, 0, 0, 16'h0000, 16'h0000};
        x[2] = '{16'h0000, 0, 0, 0, 16'h0001, 7, 2};
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            drive(v[i]);
            q.push_back(x[i]);
            #1;
            e = q.pop_front();
            n_vec++;
            if (obs1 !== e) begin
                n_err++;
                $display("FAIL alias_wrap[%0d]: got %p, expected %p", i, obs1, e);
            end
        end
    endtask

    task automatic test_jump;
        vec_t v[2];
        exp_t x[2];
        exp_t e;
        v[0] = '{0, 16'h0030, 1, 16'h0030, 0, 1, 16'h0100, 16'h0031};
        x[0] = '{16'h0031, 0, 0, 1, 16'h0100, 7, 2};
        v[1] = '{0, 16'h0030, 0, 16'h0000, 0, 0, 16'h0000, 16'h0000};
        x[1] = '{16'h0100, 1, 1, 0, 16'h0001, 8, 3};
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            drive(v[i]);
            q.push_back(x[i]);
            #1;
            e = q.pop_front();
            n_vec++;
            if (obs1 !== e) begin
                n_err++;
                $display("FAIL jump[%0d]: got %p, expected %p", i, obs1, e);
            end
        end
    endtask

    task automatic test_reset_mid;
        vec_t v[3];
        exp_t x[3];
        exp_t e;
        v[0] = '{1, 16'h0012, 1, 16'h0040, 1, 1, 16'h0123, 16'h0041};
        x[0] = '{16'h0013, 0, 0, 1, 16'h0123, 0, 0};
        v[1] = '{0, 16'h0040, 0, 16'h0000, 0, 0, 16'h0000, 16'h0000};
        x[1] = '{16'h0041, 0, 0, 0, 16'h0001, 0, 0};
        v[2] = '{0, 16'h0012, 0, 16'h0000, 0, 0, 16'h0000, 16'h0000};
        x[2] = '{16'h0013, 0, 0, 0, 16'h0001, 0, 0};
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            drive(v[i]);
            q.push_back(x[i]);
            #1;
            e = q.pop_front();
            n_vec++;
            if (obs1 !== e) begin
                n_err++;
                $display("FAIL reset_mid[%0d]: got %p, expected %p", i, obs1, e);
            end
        end
    endtask

    // T,T history makes 0x0012 index PHT entry 2^3=1, which is still weakly not taken.
    task automatic test_gshare;
        vec_t v[4];
        exp_t x[4];
        exp_t e;
        use2 = 1'b1;
        v[0] = '{0, 16'h0012, 1, 16'h0012, 1, 1, 16'h0005, 16'h0013};
        x[0] = '{16'h0013, 0, 0, 1, 16'h0005, 0, 0};
        v[1] = '{0, 16'h0012, 1, 16'h0013, 1, 1, 16'h0007, 16'h0014};
        x[1] = '{16'h0013, 1, 0, 1, 16'h0007, 1, 1};
        v[2] = '{0, 16'h0012, 0, 16'h0000, 0, 0, 16'h0000, 16'h0000};
        x[2] = '{16'h0013, 1, 0, 0, 16'h0001, 2, 2};
        v[3] = '{0, 16'h0013, 0, 16'h0000, 0, 0, 16'h0000, 16'h0000};
        x[3] = '{16'h0014, 1, 0, 0, 16'h0001, 2, 2};
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            drive(v[i]);
            q.push_back(x[i]);
            #1;
            e = q.pop_front();
            n_vec++;
            if (obs2 !== e) begin
                n_err++;
                $display("FAIL gshare[%0d]: got %p, expected %p", i, obs2, e);
            end
        end
        use2 = 1'b0;
    endtask

    task automatic test_random(input int mode);
        vec_t v;
        exp_t e, got;
        logic [3:0] li, lp, ui, up;
        logic hit, tk, uh;
        logic [15:0] act;
        use2 = mode == 2;
        @(negedge clk);
        drive('{1, 16'h0000, 0, 16'h0000, 0, 0, 16'h0000, 16'h0000});
        for (int i = 0; i < 16; i++) begin
            mv[i] = 1'b0;
            mc[i] = 2'd1;
        end
        mg  = '0;
        mpc = '0;
        mmp = '0;
        for (int n = 0; n < 300; n++) begin
            @(negedge clk);
            v.rst = 1'b0;
            v.pc  = $urandom_range(0, 15) == 0 ? 16'hFFFF : {12'($urandom_range(0, 2)), 4'($urandom_range(0, 15))};
            v.uv  = $urandom_range(0, 3) != 0;
            v.upc = {12'($urandom_range(0, 2)), 4'($urandom_range(0, 15))};
            v.br  = $urandom_range(0, 3) != 0;
            v.tk  = 1'($urandom_range(0, 1));
            v.tgt = 16'($urandom);
            case ($urandom_range(0, 2))
                0: v.ppc = v.upc + 16'd1;
                1: v.ppc = v.tgt;
                default: v.ppc = 16'($urandom);
            endcase
            drive(v);
            li  = v.pc[3:0];
            lp  = mode == 2 ? li ^ mg : li;
            hit = mv[li] && mt[li] == v.pc[15:4];
            tk  = hit && (mj[li] || mc[lp][1]);
            act = v.tk ? v.tgt : v.upc + 16'd1;
            e   = '{tk ? mtg[li] : v.pc + 16'd1, hit, tk, v.uv && act != v.ppc, act, mpc, mmp};
            q.push_back(e);
            if (v.uv) begin
                ui = v.upc[3:0];
                up = mode == 2 ? ui ^ mg : ui;
                uh = mv[ui] && mt[ui] == v.upc[15:4];
                if (v.tk) begin
                    if (!v.br) mc[up] = 2'd3;
                    else if (!uh) mc[up] = 2'd2;
                    else if (mc[up] < 2'd3) mc[up] = mc[up] + 2'd1;
                    mv[ui]  = 1'b1;
                    mt[ui]  = v.upc[15:4];
                    mtg[ui] = v.tgt;
                    mj[ui]  = !v.br;
                end else if (uh && mc[up] > 2'd0) begin
                    mc[up] = mc[up] - 2'd1;
                end
                if (v.br) mg = {mg[2:0], v.tk};
                if (mpc != 16'hFFFF) mpc = mpc + 16'd1;
                if (e.fl && mmp != 16'hFFFF) mmp = mmp + 16'd1;
            end
            #1;
            got = mode == 2 ? obs2 : obs1;
            e   = q.pop_front();
            n_vec++;
            if (got !== e) begin
                n_err++;
                $display("FAIL random_mode%0d[%0d]: got %p, expected %p", mode, n, got, e);
            end
        end
        use2 = 1'b0;
    endtask

    initial begin
        test_reset();
        test_cold_lookup();
        test_alloc();
        test_saturation();
        test_alias_wrap();
        test_jump();
        test_reset_mid();
        test_gshare();
        test_random(1);
        test_random(2);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
